jfive_alu_issue_wb: RTL

//  Issue/writeback stage around the jfive integer adder stage (1-cycle registered add/sub).

---
 rtl/jfive_alu_issue_wb_if.sv | 54 +++++
 rtl/jfive_alu_issue_wb.sv | 136 +++++++++++++
 2 files changed

// File: rtl/jfive_alu_issue_wb_if.sv
// ============================================================================
// jfive_alu_issue_wb_if: decode, adder and writeback bus of the ALU issue stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface jfive_alu_issue_wb_if #(
   parameter int XLEN      = 32,
   parameter int ID_BITS   = 4,
   parameter int RIDX_BITS = 5
);
   logic                 s_valid;
   logic                 s_ready;
   logic [ID_BITS-1:0]   s_id;
   logic [1:0]           s_op;
   logic                 s_rd_en;
   logic [RIDX_BITS-1:0] s_rd_idx;
   logic [RIDX_BITS-1:0] s_rs1_idx;
   logic [RIDX_BITS-1:0] s_rs2_idx;
   logic [XLEN-1:0]      s_imm_val;

   logic                 m_adder_cke;
   logic                 m_sub_en;
   logic                 m_imm_en;
   logic [XLEN-1:0]      m_rs1_val;
   logic [XLEN-1:0]      m_rs2_val;
   logic [XLEN-1:0]      m_imm_val;
   logic [XLEN-1:0]      s_rd_val;
   logic                 s_carry;

   logic                 m_wb_valid;
   logic [ID_BITS-1:0]   m_wb_id;
   logic                 m_wb_rd_en;
   logic [RIDX_BITS-1:0] m_wb_rd_idx;
   logic [XLEN-1:0]      m_wb_rd_val;
   logic                 m_wb_carry;
   logic                 m_wb_err;

   modport slave (
      input  s_valid, s_id, s_op, s_rd_en, s_rd_idx, s_rs1_idx, s_rs2_idx, s_imm_val,
      input  s_rd_val, s_carry,
      output s_ready, m_adder_cke, m_sub_en, m_imm_en, m_rs1_val, m_rs2_val, m_imm_val,
      output m_wb_valid, m_wb_id, m_wb_rd_en, m_wb_rd_idx, m_wb_rd_val, m_wb_carry, m_wb_err
   );

   modport master (
      output s_valid, s_id, s_op, s_rd_en, s_rd_idx, s_rs1_idx, s_rs2_idx, s_imm_val,
      output s_rd_val, s_carry,
      input  s_ready, m_adder_cke, m_sub_en, m_imm_en, m_rs1_val, m_rs2_val, m_imm_val,
      input  m_wb_valid, m_wb_id, m_wb_rd_en, m_wb_rd_idx, m_wb_rd_val, m_wb_carry, m_wb_err
   );
endinterface

`default_nettype wire

// File: rtl/jfive_alu_issue_wb.sv
// ============================================================================
// jfive_alu_issue_wb: issue/writeback stage around the 1-cycle jfive adder
// Rev 1.0
// ============================================================================
`default_nettype none

module jfive_alu_issue_wb #(
   parameter int XLEN      = 32,
   parameter int ID_BITS   = 4,
   parameter int RIDX_BITS = 5
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cke,
   jfive_alu_issue_wb_if.slave bus
);
   typedef logic [XLEN-1:0] rval_t;
   localparam int NREGS = 2**RIDX_BITS;

   rval_t                regfile [NREGS];

   logic                 i_valid;
   logic [ID_BITS-1:0]   i_id;
   logic                 i_rd_en;
   logic [RIDX_BITS-1:0] i_rd_idx;
   logic                 i_err;
   logic                 iss_sub_en;
   logic                 iss_imm_en;
   rval_t                iss_rs1_val;
   rval_t                iss_rs2_val;
   rval_t                iss_imm_val;

   logic                 e_valid;
   logic [ID_BITS-1:0]   e_id;
   logic                 e_rd_en;
   logic [RIDX_BITS-1:0] e_rd_idx;
   logic                 e_err;

   logic                 hazard;
   logic                 ready;
   logic                 accept;
   logic                 op_err;
   logic                 op_sub;
   logic                 op_imm;
   logic                 fwd_ok;
   logic                 wb_valid;
   logic                 wb_write;
   rval_t                rs1_val;
   rval_t                rs2_val;

   // Only the op one stage ahead can still be unwritten and unforwardable
   assign hazard = i_valid && i_rd_en && (i_rd_idx != '0) &&
                   ((bus.s_rs1_idx == i_rd_idx) ||
                    (!bus.s_op[0] && (bus.s_rs2_idx == i_rd_idx)));
   assign ready    = cke && !hazard;
   assign accept   = bus.s_valid && ready;
   assign op_err   = &bus.s_op;
   assign op_sub   = bus.s_op[1] && !op_err;
   assign op_imm   = bus.s_op[0] && !op_err;
   assign fwd_ok   = e_valid && e_rd_en;
   assign wb_valid = e_valid && cke;
   assign wb_write = wb_valid && e_rd_en && (e_rd_idx != '0);

   always_comb begin
      rs1_val = regfile[bus.s_rs1_idx];
      if (bus.s_rs1_idx == '0)
         rs1_val = '0;
      else if (fwd_ok && (bus.s_rs1_idx == e_rd_idx))
         rs1_val = bus.s_rd_val;

      rs2_val = regfile[bus.s_rs2_idx];
      if (op_imm || (bus.s_rs2_idx == '0))
         rs2_val = '0;
      else if (fwd_ok && (bus.s_rs2_idx == e_rd_idx))
         rs2_val = bus.s_rd_val;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NREGS; r++)
            regfile[r] <= '0;
         i_valid     <= 1'b0;
         i_id        <= '0;
         i_rd_en     <= 1'b0;
         i_rd_idx    <= '0;
         i_err       <= 1'b0;
         iss_sub_en  <= 1'b0;
         iss_imm_en  <= 1'b0;
         iss_rs1_val <= '0;
         iss_rs2_val <= '0;
         iss_imm_val <= '0;
         e_valid     <= 1'b0;
         e_id        <= '0;
         e_rd_en     <= 1'b0;
         e_rd_idx    <= '0;
         e_err       <= 1'b0;
      end else if (cke) begin
         i_valid    <= accept;
         iss_sub_en <= accept && op_sub;
         iss_imm_en <= accept && op_imm;
         if (accept) begin
            i_id        <= bus.s_id;
            i_rd_en     <= bus.s_rd_en;
            i_rd_idx    <= bus.s_rd_idx;
            i_err       <= op_err;
            iss_rs1_val <= rs1_val;
            iss_rs2_val <= rs2_val;
            iss_imm_val <= bus.s_imm_val;
         end
         e_valid  <= i_valid;
         e_id     <= i_id;
         e_rd_en  <= i_rd_en;
         e_rd_idx <= i_rd_idx;
         e_err    <= i_err;
         if (wb_write)
            regfile[e_rd_idx] <= bus.s_rd_val;
      end
   end

   assign bus.s_ready     = ready;
   assign bus.m_adder_cke = cke;
   assign bus.m_sub_en    = iss_sub_en;
   assign bus.m_imm_en    = iss_imm_en;
   assign bus.m_rs1_val   = iss_rs1_val;
   assign bus.m_rs2_val   = iss_rs2_val;
   assign bus.m_imm_val   = iss_imm_val;
   assign bus.m_wb_valid  = wb_valid;
   assign bus.m_wb_id     = e_id;
   assign bus.m_wb_rd_en  = e_rd_en;
   assign bus.m_wb_rd_idx = e_rd_idx;
   assign bus.m_wb_rd_val = bus.s_rd_val;
   assign bus.m_wb_carry  = bus.s_carry;
   assign bus.m_wb_err    = e_err;
endmodule

`default_nettype wire
